// File: rtl/bus_arbiter.sv
// Two-master bus front end: grant FSM, bus mux and read-data return.
// M0 is the default owner; M1 keeps the bus for as long as it requests it.
module bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    input  logic [DATA_W-1:0] s2_dout,
    output logic [DATA_W-1:0] m_din
);

    // One-hot state encoding so the grants come straight off the register.
    typedef enum logic [1:0] {
        M0_GRANT = 2'b01,
        M1_GRANT = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] rsel;

    // Grant FSM: M0 wins ties, M1 is never preempted while it requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= M0_GRANT;
        end else begin
            case (state)
                M0_GRANT: if (!m0_req && m1_req) state <= M1_GRANT;
                M1_GRANT: if (!m1_req) state <= M0_GRANT;
                default:  state <= M0_GRANT;
            endcase
        end
    end

    assign m0_grant = state[0];
    assign m1_grant = state[1];

    // Bus mux follows the grant in the same cycle, so handover has no gap.
    always_comb begin
        s_wr   = m0_wr;
        s_addr = m0_addr;
        s_din  = m0_dout;
        if (m1_grant) begin
            s_wr   = m1_wr;
            s_addr = m1_addr;
            s_din  = m1_dout;
        end
    end

    // Slave index delayed one cycle to line up with registered slave data.
    always_ff @(posedge clk) begin
        if (reset) rsel <= 4'hF;
        else       rsel <= s_addr[ADDR_W-1 -: 4];
    end

    // Read-data return; unmapped slave indices read as zero.
    always_comb begin
        case (rsel)
            4'h0:    m_din = s0_dout;
            4'h1:    m_din = s1_dout;
            4'h2:    m_din = s2_dout;
            default: m_din = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_bus_arbiter;

    logic        clk = 0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_dout, m1_dout, s_din;
    logic [31:0] s0_dout, s1_dout, s2_dout, m_din;
    logic        m0_grant, m1_grant, s_wr;

    bus_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
        .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout),
        .m_din(m_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [1:0]  g;
        logic        cb;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] din;
        logic        cm;
        logic [31:0] md;
    } exp_t;

    exp_t q[$];
    int   ntag   = 0;
    int   checks = 0;
    int   errors = 0;
    logic done   = 0;

    localparam logic [1:0] G0 = 2'b01;
    localparam logic [1:0] G1 = 2'b10;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic cb, input logic wr,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic cm, input logic [31:0] md);
        exp_t e;
        e.tag = ntag; e.g = g; e.cb = cb; e.wr = wr;
        e.addr = a; e.din = d; e.cm = cm; e.md = md;
        q.push_back(e);
        ntag++;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    exp_t e;
    int   drain = 0;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({m1_grant, m0_grant} !== e.g) begin
                errors++;
                $display("FAIL grant #%0d: got %b want %b", e.tag,
                         {m1_grant, m0_grant}, e.g);
            end
            if (e.cb) begin
                checks++;
                if (s_wr !== e.wr || s_addr !== e.addr || s_din !== e.din) begin
                    errors++;
                    $display("FAIL bus #%0d: got wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                             e.tag, s_wr, s_addr, s_din, e.wr, e.addr, e.din);
                end
            end
            if (e.cm) begin
                checks++;
                if (m_din !== e.md) begin
                    errors++;
                    $display("FAIL m_din #%0d: got %h want %h", e.tag, m_din, e.md);
                end
            end
        end else if (done) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (done) begin
            drain++;
            if (drain > 50) begin
                errors++;
                $display("FAIL drain: got %0d pending want 0", q.size());
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        s0_dout = 32'hA0; s1_dout = 32'hB1; s2_dout = 32'hC2;
        m0_req = 0; m0_wr = 1; m0_addr = 16'h5A5A; m0_dout = 32'h1111;
        m1_req = 1; m1_wr = 0; m1_addr = 16'h1004; m1_dout = 32'h2222;
        reset = 1;

        // Reset held with m1_req high: M0 owns the bus, m_din is zero.
        cyc(); push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 0);
        cyc(); reset = 0;
        push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 0);
        // Handover to M1 one cycle after release; drop its request.
        cyc(); m1_req = 0;
        push(G1, 1, 0, 16'h1004, 32'h2222, 1, 0);
        // Back to M0 with m0_req low; data for M1's address arrives now.
        cyc(); push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 32'hB1);
        cyc(); push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 0);

        // Both requesting from reset: M0 keeps the bus.
        cyc(); reset = 1; m0_req = 1; m1_req = 1;
        push(G0, 0, 0, 0, 0, 0, 0);
        cyc(); reset = 0;
        push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(); push(G0, 1, 1, 16'h5A5A, 32'h1111, 1, 0);
        end

        // Back-to-back M0 reads to slaves 0,1,2,3.
        cyc(); m0_wr = 0; m0_addr = 16'h0010;
        push(G0, 1, 0, 16'h0010, 32'h1111, 1, 0);
        cyc(); m0_addr = 16'h1020;
        push(G0, 1, 0, 16'h1020, 32'h1111, 1, 32'hA0);
        cyc(); m0_addr = 16'h2030;
        push(G0, 1, 0, 16'h2030, 32'h1111, 1, 32'hB1);
        cyc(); m0_addr = 16'h3000;
        push(G0, 1, 0, 16'h3000, 32'h1111, 1, 32'hC2);
        cyc(); m0_addr = 16'h5A5A;
        push(G0, 1, 0, 16'h5A5A, 32'h1111, 1, 0);

        // M1 write while M0 inputs toggle.
        cyc(); m0_req = 0;
        push(G0, 1, 0, 16'h5A5A, 32'h1111, 1, 0);
        cyc(); m0_req = 1; m0_wr = 0; m0_addr = 16'h2FFF; m0_dout = 32'h12345678;
        m1_wr = 1; m1_addr = 16'h1008; m1_dout = 32'hDEADBEEF;
        push(G1, 1, 1, 16'h1008, 32'hDEADBEEF, 1, 0);
        cyc(); m0_wr = 1; m0_addr = 16'h0000; m0_dout = 32'hEDCBA987;
        push(G1, 1, 1, 16'h1008, 32'hDEADBEEF, 1, 32'hB1);

        // Reads to slave 1, then reset lands on the second one.
        cyc(); m1_wr = 0; m1_addr = 16'h1010;
        push(G1, 1, 0, 16'h1010, 32'hDEADBEEF, 1, 32'hB1);
        cyc(); reset = 1; m1_addr = 16'h1014;
        push(G1, 1, 0, 16'h1014, 32'hDEADBEEF, 1, 32'hB1);
        cyc(); reset = 0;
        push(G0, 1, 1, 16'h0000, 32'hEDCBA987, 1, 0);
        cyc(); push(G0, 1, 1, 16'h0000, 32'hEDCBA987, 1, 32'hA0);

        done = 1;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Master-side front end of the shared system bus: arbitrates between two bus masters (M0, M1), drives the granted master's address, write strobe and write data onto the shared bus, and returns slave read data to the masters. It sits opposite the slave-select address decoder; the upper 4 bits of the bus address it drives feed that decoder. Slave read data is registered, so the return path keeps a one-cycle-delayed copy of the slave index.

## Interface
- ADDR_W, 16, bus address width; upper 4 bits are the slave index
- DATA_W, 32, bus data width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  M0 bus request, level
- m0_wr  in  1  M0 write strobe (1 = write, 0 = read)
- m0_addr  in  ADDR_W  M0 address
- m0_dout  in  DATA_W  M0 write data
- m1_req, m1_wr, m1_addr, m1_dout  in  1/1/ADDR_W/DATA_W  same for M1
- m0_grant  out  1  M0 owns the bus
- m1_grant  out  1  M1 owns the bus
- s_wr  out  1  bus write strobe to slaves
- s_addr  out  ADDR_W  bus address to slaves and decoder
- s_din  out  DATA_W  bus write data to slaves
- s0_dout, s1_dout, s2_dout  in  DATA_W  registered read data from slaves 0/1/2
- m_din  out  DATA_W  read data returned to both masters

## Operation
- FSM, 2 states, one-hot grant outputs taken directly from state register:
  - M0_GRANT (m0_grant=1, m1_grant=0): go to M1_GRANT iff m0_req=0 and m1_req=1; else stay.
  - M1_GRANT (m0_grant=0, m1_grant=1): stay iff m1_req=1; else go to M0_GRANT (regardless of m0_req).
- M0 is default owner and wins ties when the bus is in M0_GRANT; M1 holds the bus as long as it keeps m1_req high (no preemption).
- Exactly one grant is high in every cycle, including during and after reset; never 00 or 11.
- Bus mux (combinational from grant): M0_GRANT → s_addr=m0_addr, s_wr=m0_wr, s_din=m0_dout; M1_GRANT → M1 signals.
- A master that does not own the bus has its inputs ignored entirely.
- Read return: rsel (4-bit register) loads s_addr[ADDR_W-1:ADDR_W-4] every cycle. m_din = s0_dout if rsel=0, s1_dout if 1, s2_dout if 2, all zeros otherwise (any index 3..F).
- rsel is loaded on writes too; m_din after a write is don't-care for masters but must still follow the select rule.

## Timing
- Reset (synchronous): state=M0_GRANT, rsel=4'hF; so m0_grant=1, m1_grant=0, m_din=0, s_addr/s_wr/s_din = M0 inputs.
- Grant latency: request change sampled at edge N → grant changes visible after edge N (one cycle). Master must see its grant high before driving a transaction; a transaction is the cycle(s) in which its grant is high.
- Handover costs no dead cycle: bus follows new grant the same cycle the grant changes.
- Read latency: address driven in cycle N → matching data on m_din in cycle N+1. Back-to-back reads to different slaves return in order, one per cycle.
- Ownership change between an address cycle and its data cycle does not disturb the return: data for the address issued by the previous owner appears in the first cycle of the new owner.
- Reset mid-transfer: grant forced to M0 and m_din forced to 0 at the next edge, regardless of requests; any pending read data is discarded.

## Test plan
- Reset with m1_req=1 held: during and one cycle after reset m0_grant=1, m1_grant=0, m_din=0; grant moves to M1 one cycle after reset release only if m0_req=0.
- m0_req=0, m1_req=1 from M0_GRANT: m1_grant=1 next cycle; s_addr=m1_addr=16'h1004; drop m1_req → m0_grant=1 next cycle even with m0_req=0.
- Both requests high continuously from reset: M0 keeps the bus for 20 cycles, m1_grant never asserts; one-hot checked every cycle.
- M0 reads 16'h0010, 16'h1020, 16'h2030, 16'h3000 on consecutive cycles with s0/s1/s2_dout = 32'hA0,32'hB1,32'hC2: m_din = A0, B1, C2, 0 on the following cycles.
- M1 write 16'h1008 data 32'hDEAD_BEEF while granted: s_wr=1, s_addr=16'h1008, s_din=32'hDEADBEEF same cycle; M0 inputs toggling have no effect on bus outputs.
- Assert reset in the cycle after a read issue to slave 1: m_din=0 next cycle instead of s1_dout, grant returns to M0.
